// File: rtl/lcd_write_ctrl_if.sv
// lcd_write_ctrl_if
// Write-request handshake between a host and lcd_write_ctrl.
//   wr_valid : host -> ctrl  write request
//   wr_ready : ctrl -> host  controller accepts a request this cycle
//   wr_rs    : host -> ctrl  0 = command, 1 = character
//   wr_data  : host -> ctrl  byte to write
// A transfer happens on a rising clock edge with wr_valid and wr_ready both high.
interface lcd_write_ctrl_if;
  logic       wr_valid;
  logic       wr_ready;
  logic       wr_rs;
  logic [7:0] wr_data;

  modport master (
    output wr_valid,
    output wr_rs,
    output wr_data,
    input  wr_ready
  );

  modport slave (
    input  wr_valid,
    input  wr_rs,
    input  wr_data,
    output wr_ready
  );
endinterface

// File: rtl/lcd_write_ctrl.sv
// lcd_write_ctrl
// HD44780-style LCD write controller. After reset it waits T_POWERUP cycles,
// issues the init command list, then accepts host writes and strobes each one
// onto the LCD bus with programmable setup / enable / hold / post-write timing.
// In 4-bit mode every byte goes out as two nibbles on lcd_data[7:4].
// Ports:
//   clk, rst_n  : system clock (rising edge), asynchronous active-low reset
//   wr          : write handshake (slave side of lcd_write_ctrl_if)
//   init_done   : init sequence complete (sticky until reset)
//   busy        : controller is not idle
//   lcd_data    : LCD DB7..DB0
//   lcd_rs      : register select
//   lcd_rw      : read/write, tied to write (0)
//   lcd_en      : enable strobe
//   lcd_on      : panel power/backlight enable, always 1
module lcd_write_ctrl #(
  parameter int unsigned BUS_WIDTH = 8,
  parameter int unsigned T_POWERUP = 750000,
  parameter int unsigned T_SETUP   = 4,
  parameter int unsigned T_EN      = 25,
  parameter int unsigned T_HOLD    = 4,
  parameter int unsigned T_CMD     = 2000,
  parameter int unsigned T_CLEAR   = 80000
) (
  input  logic            clk,
  input  logic            rst_n,
  lcd_write_ctrl_if.slave wr,
  output logic            init_done,
  output logic            busy,
  output logic [7:0]      lcd_data,
  output logic            lcd_rs,
  output logic            lcd_rw,
  output logic            lcd_en,
  output logic            lcd_on
);

  localparam int unsigned MAX_A = (T_POWERUP > T_CLEAR) ? T_POWERUP : T_CLEAR;
  localparam int unsigned MAX_B = (T_CMD > T_EN) ? T_CMD : T_EN;
  localparam int unsigned MAX_C = (T_SETUP > T_HOLD) ? T_SETUP : T_HOLD;
  localparam int unsigned MAX_D = (MAX_A > MAX_B) ? MAX_A : MAX_B;
  localparam int unsigned MAXT  = (MAX_D > MAX_C) ? MAX_D : MAX_C;
  // The counter is loaded with T-1, so it only has to hold MAXT-1.
  localparam int unsigned CW    = (MAXT < 2) ? 1 : $clog2(MAXT);

  localparam logic [CW-1:0] POWERUP_LD = CW'(T_POWERUP - 1);
  localparam logic [CW-1:0] SETUP_LD   = CW'(T_SETUP - 1);
  localparam logic [CW-1:0] EN_LD      = CW'(T_EN - 1);
  localparam logic [CW-1:0] HOLD_LD    = CW'(T_HOLD - 1);
  localparam logic [CW-1:0] CMD_LD     = CW'(T_CMD - 1);
  localparam logic [CW-1:0] CLEAR_LD   = CW'(T_CLEAR - 1);

  localparam logic [2:0] INIT_LAST = (BUS_WIDTH == 4) ? 3'd7 : 3'd3;

  typedef enum logic [2:0] {
    S_POWERUP,
    S_INIT_LOAD,
    S_IDLE,
    S_SETUP,
    S_EN_HIGH,
    S_HOLD,
    S_WAIT
  } state_t;

  state_t        state_q, state_d;
  logic [CW-1:0] cnt_q, cnt_d;
  logic [2:0]    idx_q, idx_d;
  logic [7:0]    byte_q, byte_d;
  logic          rs_q, rs_d;
  logic          single_q, single_d;   // init entry that is a lone nibble
  logic          phase_q, phase_d;     // 4-bit mode: 0 = high nibble, 1 = low nibble
  logic          init_done_q, init_done_d;
  logic          ready_q, ready_d;
  logic          fire;
  logic          long_wait;

  // Init list entry: {single_nibble, byte}. Single nibbles sit in the high half.
  function automatic logic [8:0] init_entry(input logic [2:0] idx);
    logic [8:0] e;
    e = '0;
    if (BUS_WIDTH == 4) begin
      case (idx)
        3'd0, 3'd1, 3'd2: e = {1'b1, 8'h30};
        3'd3:             e = {1'b1, 8'h20};
        3'd4:             e = {1'b0, 8'h28};
        3'd5:             e = {1'b0, 8'h0C};
        3'd6:             e = {1'b0, 8'h06};
        default:          e = {1'b0, 8'h01};
      endcase
    end else begin
      case (idx)
        3'd0:    e = {1'b0, 8'h38};
        3'd1:    e = {1'b0, 8'h0C};
        3'd2:    e = {1'b0, 8'h06};
        default: e = {1'b0, 8'h01};
      endcase
    end
    return e;
  endfunction

  assign fire      = ready_q && wr.wr_valid;
  assign long_wait = !rs_q && !single_q &&
                     ((byte_q == 8'h01) || (byte_q == 8'h02) || (byte_q == 8'h03));

  always_comb begin
    state_d     = state_q;
    cnt_d       = cnt_q;
    idx_d       = idx_q;
    byte_d      = byte_q;
    rs_d        = rs_q;
    single_d    = single_q;
    phase_d     = phase_q;
    init_done_d = init_done_q;

    unique case (state_q)
      S_POWERUP: begin
        if (cnt_q == '0) state_d = S_INIT_LOAD;
        else             cnt_d   = cnt_q - 1'b1;
      end
      S_INIT_LOAD: begin
        {single_d, byte_d} = init_entry(idx_q);
        rs_d    = 1'b0;
        phase_d = 1'b0;
        state_d = S_SETUP;
        cnt_d   = SETUP_LD;
      end
      S_IDLE: begin
        if (fire) begin
          rs_d     = wr.wr_rs;
          byte_d   = wr.wr_data;
          single_d = 1'b0;
          phase_d  = 1'b0;
          state_d  = S_SETUP;
          cnt_d    = SETUP_LD;
        end
      end
      S_SETUP: begin
        if (cnt_q == '0) begin
          state_d = S_EN_HIGH;
          cnt_d   = EN_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_EN_HIGH: begin
        if (cnt_q == '0) begin
          state_d = S_HOLD;
          cnt_d   = HOLD_LD;
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_HOLD: begin
        if (cnt_q == '0) begin
          if ((BUS_WIDTH == 4) && !single_q && !phase_q) begin
            phase_d = 1'b1;
            state_d = S_SETUP;
            cnt_d   = SETUP_LD;
          end else begin
            state_d = S_WAIT;
            cnt_d   = long_wait ? CLEAR_LD : CMD_LD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      S_WAIT: begin
        if (cnt_q == '0) begin
          if (init_done_q) begin
            state_d = S_IDLE;
          end else if (idx_q == INIT_LAST) begin
            state_d     = S_IDLE;
            init_done_d = 1'b1;
          end else begin
            idx_d   = idx_q + 1'b1;
            state_d = S_INIT_LOAD;
          end
        end else begin
          cnt_d = cnt_q - 1'b1;
        end
      end
      default: state_d = S_POWERUP;
    endcase
  end

  // Registered ready: it rises one cycle after IDLE is entered, which gives the
  // trailing idle cycle in the accept-to-accept spacing.
  assign ready_d = (state_q == S_IDLE) && init_done_q && !fire;

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      state_q     <= S_POWERUP;
      cnt_q       <= POWERUP_LD;
      idx_q       <= '0;
      byte_q      <= '0;
      rs_q        <= 1'b0;
      single_q    <= 1'b0;
      phase_q     <= 1'b0;
      init_done_q <= 1'b0;
      ready_q     <= 1'b0;
    end else begin
      state_q     <= state_d;
      cnt_q       <= cnt_d;
      idx_q       <= idx_d;
      byte_q      <= byte_d;
      rs_q        <= rs_d;
      single_q    <= single_d;
      phase_q     <= phase_d;
      init_done_q <= init_done_d;
      ready_q     <= ready_d;
    end
  end

  // The bus follows the captured byte; it only changes on entry to SETUP.
  always_comb begin
    if (BUS_WIDTH == 4) lcd_data = {(phase_q ? byte_q[3:0] : byte_q[7:4]), 4'h0};
    else                lcd_data = byte_q;
  end

  assign lcd_rs      = rs_q;
  assign lcd_en      = (state_q == S_EN_HIGH);
  assign lcd_rw      = 1'b0;
  assign lcd_on      = 1'b1;
  assign busy        = (state_q != S_IDLE);
  assign init_done   = init_done_q;
  assign wr.wr_ready = ready_q;

endmodule

// File: tb/tb_lcd_write_ctrl.sv
// Bench for lcd_write_ctrl: one 8-bit and one 4-bit instance with short timings.
// Stimulus pushes the expected LCD strobes into per-instance queues; a monitor
// pops and compares on every lcd_en rising edge and also checks strobe timing.
module tb_lcd_write_ctrl;
  localparam int T_POWERUP = 20;
  localparam int T_SETUP   = 2;
  localparam int T_EN      = 3;
  localparam int T_HOLD    = 1;
  localparam int T_CMD     = 5;
  localparam int T_CLEAR   = 12;

  logic clk = 1'b0;
  logic rst_n;
  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  lcd_write_ctrl_if bus8 ();
  lcd_write_ctrl_if bus4 ();

  logic       done_w [2];
  logic       busy_w [2];
  logic [7:0] data_w [2];
  logic       rs_w   [2];
  logic       rw_w   [2];
  logic       en_w   [2];
  logic       on_w   [2];

  lcd_write_ctrl #(.BUS_WIDTH(8), .T_POWERUP(T_POWERUP), .T_SETUP(T_SETUP), .T_EN(T_EN),
                   .T_HOLD(T_HOLD), .T_CMD(T_CMD), .T_CLEAR(T_CLEAR)) dut8 (
    .clk(clk), .rst_n(rst_n), .wr(bus8),
    .init_done(done_w[0]), .busy(busy_w[0]), .lcd_data(data_w[0]), .lcd_rs(rs_w[0]),
    .lcd_rw(rw_w[0]), .lcd_en(en_w[0]), .lcd_on(on_w[0]));

  lcd_write_ctrl #(.BUS_WIDTH(4), .T_POWERUP(T_POWERUP), .T_SETUP(T_SETUP), .T_EN(T_EN),
                   .T_HOLD(T_HOLD), .T_CMD(T_CMD), .T_CLEAR(T_CLEAR)) dut4 (
    .clk(clk), .rst_n(rst_n), .wr(bus4),
    .init_done(done_w[1]), .busy(busy_w[1]), .lcd_data(data_w[1]), .lcd_rs(rs_w[1]),
    .lcd_rw(rw_w[1]), .lcd_en(en_w[1]), .lcd_on(on_w[1]));

  int errors = 0;
  int checks = 0;

  logic [8:0] exp0 [$];
  logic [8:0] exp1 [$];

  logic       en_prev  [2];
  logic [8:0] bus_prev [2];
  int         hi [2];
  int         lo [2];
  int         stab [2];
  logic       done_seen [2];

  task automatic chk(input string name, input logic [31:0] act, input logic [31:0] expv);
    checks++;
    if (act !== expv) begin
      errors++;
      $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, expv, $time);
    end
  endtask

  function automatic int bw(input int d);
    return (d == 0) ? 8 : 4;
  endfunction

  // Reference timing: one accept-to-accept period for a byte.
  function automatic int spacing(input int w, input logic r, input logic [7:0] b);
    int post, strobe;
    post   = (!r && (b >= 8'h01) && (b <= 8'h03)) ? T_CLEAR : T_CMD;
    strobe = T_SETUP + T_EN + T_HOLD;
    return 1 + strobe * ((w == 4) ? 2 : 1) + post + 1;
  endfunction

  // Reference timing: cycles from reset release to init_done. Each init entry
  // costs one load cycle plus its strobe(s) and post wait.
  function automatic int init_cycles(input int w);
    int t, s;
    s = T_SETUP + T_EN + T_HOLD;
    t = T_POWERUP;
    if (w == 4) t += 4 * (1 + s + T_CMD) + 3 * (1 + 2 * s + T_CMD) + (1 + 2 * s + T_CLEAR);
    else        t += 3 * (1 + s + T_CMD) + (1 + s + T_CLEAR);
    return t;
  endfunction

  function automatic logic ready(input int d);
    return (d == 0) ? bus8.wr_ready : bus4.wr_ready;
  endfunction

  function automatic int qsize(input int d);
    return (d == 0) ? exp0.size() : exp1.size();
  endfunction

  task automatic push1(input int d, input logic [8:0] e);
    if (d == 0) exp0.push_back(e);
    else        exp1.push_back(e);
  endtask

  task automatic push_exp(input int d, input logic r, input logic [7:0] b);
    if (bw(d) == 4) begin
      push1(d, {r, b[7:4], 4'h0});
      push1(d, {r, b[3:0], 4'h0});
    end else begin
      push1(d, {r, b});
    end
  endtask

  task automatic push_init(input int d);
    logic [7:0] bytes8 [4];
    logic [3:0] nibs [4];
    bytes8 = '{8'h38, 8'h0C, 8'h06, 8'h01};
    nibs   = '{4'h3, 4'h3, 4'h3, 4'h2};
    if (bw(d) == 4) begin
      foreach (nibs[i]) push1(d, {1'b0, nibs[i], 4'h0});
      push_exp(d, 1'b0, 8'h28);
      push_exp(d, 1'b0, 8'h0C);
      push_exp(d, 1'b0, 8'h06);
      push_exp(d, 1'b0, 8'h01);
    end else begin
      foreach (bytes8[i]) push1(d, {1'b0, bytes8[i]});
    end
  endtask

  task automatic drive(input int d, input logic v, input logic r, input logic [7:0] b);
    if (d == 0) begin bus8.wr_valid = v; bus8.wr_rs = r; bus8.wr_data = b; end
    else        begin bus4.wr_valid = v; bus4.wr_rs = r; bus4.wr_data = b; end
  endtask

  task automatic mon(input int d);
    logic       en, dn, bz;
    logic [7:0] dt;
    logic [8:0] bus, e;
    en  = en_w[d];
    dn  = done_w[d];
    bz  = busy_w[d];
    dt  = data_w[d];
    bus = {rs_w[d], dt};
    if (!rst_n) begin
      en_prev[d] = 1'b0; hi[d] = 0; lo[d] = 100; stab[d] = 1;
      bus_prev[d] = bus; done_seen[d] = 1'b0;
      return;
    end
    chk($sformatf("rw_on_%0d", d), {rw_w[d], on_w[d]}, 2'b01);
    if (d == 1) chk("nibble_low_zero", dt[3:0], 4'h0);
    if (ready(d)) chk($sformatf("busy_when_ready_%0d", d), bz, 1'b0);
    if (en) chk($sformatf("busy_when_en_%0d", d), bz, 1'b1);
    if (done_seen[d]) chk($sformatf("init_done_sticky_%0d", d), dn, 1'b1);
    if (dn) done_seen[d] = 1'b1;
    if (bus != bus_prev[d]) begin
      chk($sformatf("hold_%0d", d), (!en && (lo[d] >= T_HOLD)), 1'b1);
      stab[d] = 1;
    end else begin
      stab[d]++;
    end
    if (en && !en_prev[d]) begin
      if (qsize(d) == 0) begin
        checks++;
        errors++;
        $display("FAIL unexpected_strobe_%0d: got %0h expected none", d, bus);
      end else begin
        e = (d == 0) ? exp0.pop_front() : exp1.pop_front();
        chk($sformatf("strobe_%0d", d), bus, e);
      end
      chk($sformatf("setup_%0d", d), stab[d] >= T_SETUP + 1, 1'b1);
    end
    if (en) hi[d]++;
    else if (en_prev[d]) begin
      chk($sformatf("en_width_%0d", d), hi[d], T_EN);
      hi[d] = 0;
    end
    if (en) lo[d] = 0;
    else    lo[d]++;
    en_prev[d]  = en;
    bus_prev[d] = bus;
  endtask

  always @(negedge clk) begin
    mon(0);
    mon(1);
  end

  task automatic wait_init(input int d);
    int n;
    n = 0;
    while (!done_w[d] && n < 2000) begin
      @(negedge clk);
      n++;
    end
    chk($sformatf("init_cycles_%0d", d), n, init_cycles(bw(d)));
    @(negedge clk);
    chk($sformatf("ready_after_init_%0d", d), ready(d), 1'b1);
  endtask

  task automatic release_reset();
    #2 rst_n = 1'b1;
    push_init(0);
    push_init(1);
    fork
      wait_init(0);
      wait_init(1);
    join
  endtask

  task automatic do_write(input int d, input logic r, input logic [7:0] b, output int acc);
    int n;
    n = 0;
    drive(d, 1'b1, r, b);
    while (!ready(d) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!ready(d)) begin
      checks++;
      errors++;
      $display("FAIL accept_timeout_%0d: got ready=0 expected ready=1", d);
      drive(d, 1'b0, r, b);
      acc = cyc;
      return;
    end
    @(posedge clk);
    @(negedge clk);
    acc = cyc;
    push_exp(d, r, b);
  endtask

  task automatic wait_ready(input int d, output int rc);
    int n;
    n = 0;
    while (!ready(d) && n < 500) begin
      @(negedge clk);
      n++;
    end
    if (!ready(d)) begin
      checks++;
      errors++;
      $display("FAIL ready_timeout_%0d: got ready=0 expected ready=1", d);
    end
    rc = cyc;
  endtask

  task automatic single_write(input int d, input logic r, input logic [7:0] b);
    int acc, rc;
    do_write(d, r, b, acc);
    drive(d, 1'b0, 1'($urandom), 8'($urandom));  // junk while ready is low
    wait_ready(d, rc);
    chk($sformatf("post_wait_%0d_%0h", d, b), rc - acc, spacing(bw(d), r, b) - 1);
  endtask

  task automatic burst(input int d, input logic r1, input logic [7:0] b1,
                       input logic r2, input logic [7:0] b2);
    int a1, a2, rc;
    do_write(d, r1, b1, a1);
    do_write(d, r2, b2, a2);
    drive(d, 1'b0, 1'($urandom), 8'($urandom));
    chk($sformatf("burst_spacing_%0d_%0h", d, b1), a2 - a1, spacing(bw(d), r1, b1));
    wait_ready(d, rc);
    chk($sformatf("post_wait_%0d_%0h", d, b2), rc - a2, spacing(bw(d), r2, b2) - 1);
  endtask

  function automatic logic [7:0] rand_byte();
    if ($urandom_range(3, 0) == 0) return 8'($urandom_range(3, 1));
    return 8'($urandom);
  endfunction

  task automatic random_phase(input int d, input int count);
    for (int i = 0; i < count; i++) begin
      if ($urandom_range(2, 0) == 0)
        burst(d, 1'($urandom), rand_byte(), 1'($urandom), rand_byte());
      else
        single_write(d, 1'($urandom), rand_byte());
      repeat ($urandom_range(3, 0)) @(negedge clk);
    end
  endtask

  initial begin
    int acc, n;
    rst_n = 1'b0;
    drive(0, 1'b0, 1'b0, 8'h00);
    drive(1, 1'b0, 1'b0, 8'h00);
    repeat (3) @(negedge clk);
    for (int d = 0; d < 2; d++) begin
      chk($sformatf("rst_en_%0d", d), en_w[d], 1'b0);
      chk($sformatf("rst_bus_%0d", d), {rs_w[d], data_w[d]}, 9'h000);
      chk($sformatf("rst_rw_on_%0d", d), {rw_w[d], on_w[d]}, 2'b01);
      chk($sformatf("rst_ready_%0d", d), ready(d), 1'b0);
      chk($sformatf("rst_done_busy_%0d", d), {done_w[d], busy_w[d]}, 2'b01);
    end
    release_reset();

    single_write(0, 1'b1, 8'h48);
    single_write(0, 1'b0, 8'h01);
    single_write(0, 1'b0, 8'h0C);
    single_write(0, 1'b0, 8'h02);
    single_write(0, 1'b1, 8'h03);
    burst(0, 1'b1, 8'h48, 1'b1, 8'h49);
    burst(0, 1'b0, 8'h03, 1'b1, 8'h41);
    random_phase(0, 12);

    single_write(1, 1'b1, 8'h48);
    single_write(1, 1'b0, 8'h01);
    burst(1, 1'b1, 8'hA5, 1'b0, 8'h0C);
    random_phase(1, 6);

    // Reset while the 8-bit instance is in the middle of an enable pulse.
    do_write(0, 1'b1, 8'h5A, acc);
    drive(0, 1'b0, 1'b0, 8'h00);
    n = 0;
    while (!en_w[0] && n < 50) begin
      @(negedge clk);
      n++;
    end
    chk("en_before_reset", en_w[0], 1'b1);
    #1 rst_n = 1'b0;
    #1;
    chk("midreset_en", en_w[0], 1'b0);
    chk("midreset_done", done_w[0], 1'b0);
    chk("midreset_busy", busy_w[0], 1'b1);
    chk("midreset_ready", ready(0), 1'b0);
    chk("midreset_bus", {rs_w[0], data_w[0]}, 9'h000);
    exp0.delete();
    exp1.delete();
    @(negedge clk);
    @(negedge clk);
    release_reset();

    single_write(0, 1'b1, 8'h33);
    single_write(1, 1'b1, 8'h33);
    repeat (5) @(negedge clk);
    chk("queue_empty_0", exp0.size(), 0);
    chk("queue_empty_1", exp1.size(), 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end
endmodule
